// File: rtl/fas_fft_unpacker.sv
// -----------------------------------------------------------------------------
// fas_fft_unpacker
//
// Receive-side adapter for the FAS frequency-analysis output. A 16-point FFT
// frame arrives in parallel (fft_d0..fft_d15) under a one-cycle fft_valid
// strobe. It is stored in a small circular buffer of FRAMES slots and replayed
// as 16 serial complex words under a valid/ready handshake.
//
// Parameters
//   FRAMES  frame slots in the buffer (1 or 2)
//   CNT_W   width of the delivered-frame counter
//
// Ports
//   clk                 single clock, rising edge
//   rst                 synchronous active-high reset
//   fft_valid           input frame strobe
//   fft_d0..fft_d15     bin k: [31:16] real, [15:0] imaginary (signed 16-bit)
//   out_ready           downstream accepts the current word
//   out_valid           output word is valid
//   out_real/out_imag   real / imaginary part of the current word
//   out_index           bin number 0..15 of the current word
//   out_last            high with index 15
//   frame_cnt           frames fully delivered (wraps)
//   overflow            sticky, set when a frame is dropped
//   busy                at least one slot occupied
//
// Build option
//   FAS_FFT_BITREV_EN   when defined, word i is captured from fft_d[bitrev4(i)]
//                       so a bit-reversed FFT output is replayed in natural
//                       order; out_index still reports i.
// -----------------------------------------------------------------------------
module fas_fft_unpacker #(
  parameter int FRAMES = 2,
  parameter int CNT_W  = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             fft_valid,
  input  logic [31:0]      fft_d0,
  input  logic [31:0]      fft_d1,
  input  logic [31:0]      fft_d2,
  input  logic [31:0]      fft_d3,
  input  logic [31:0]      fft_d4,
  input  logic [31:0]      fft_d5,
  input  logic [31:0]      fft_d6,
  input  logic [31:0]      fft_d7,
  input  logic [31:0]      fft_d8,
  input  logic [31:0]      fft_d9,
  input  logic [31:0]      fft_d10,
  input  logic [31:0]      fft_d11,
  input  logic [31:0]      fft_d12,
  input  logic [31:0]      fft_d13,
  input  logic [31:0]      fft_d14,
  input  logic [31:0]      fft_d15,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [15:0]      out_real,
  output logic [15:0]      out_imag,
  output logic [3:0]       out_index,
  output logic             out_last,
  output logic [CNT_W-1:0] frame_cnt,
  output logic             overflow,
  output logic             busy
);

  typedef enum logic {IDLE, SEND} state_t;

  localparam logic [1:0] OCC_MAX = 2'(FRAMES);

  // Pointer advance; with a single slot both pointers stay at 0.
  function automatic logic ptr_inc(input logic p);
    return (FRAMES == 1) ? 1'b0 : ~p;
  endfunction

`ifdef FAS_FFT_BITREV_EN
  function automatic logic [3:0] bitrev4(input logic [3:0] v);
    return {v[0], v[1], v[2], v[3]};
  endfunction
`endif

  logic [31:0] fft_d    [16];
  logic [31:0] cap_word [16];

  assign fft_d[0]  = fft_d0;   assign fft_d[1]  = fft_d1;
  assign fft_d[2]  = fft_d2;   assign fft_d[3]  = fft_d3;
  assign fft_d[4]  = fft_d4;   assign fft_d[5]  = fft_d5;
  assign fft_d[6]  = fft_d6;   assign fft_d[7]  = fft_d7;
  assign fft_d[8]  = fft_d8;   assign fft_d[9]  = fft_d9;
  assign fft_d[10] = fft_d10;  assign fft_d[11] = fft_d11;
  assign fft_d[12] = fft_d12;  assign fft_d[13] = fft_d13;
  assign fft_d[14] = fft_d14;  assign fft_d[15] = fft_d15;

  // Word order mapping is fixed at capture time; the read side never knows.
  always_comb begin
    for (int i = 0; i < 16; i++) begin
`ifdef FAS_FFT_BITREV_EN
      cap_word[i] = fft_d[bitrev4(4'(i))];
`else
      cap_word[i] = fft_d[i];
`endif
    end
  end

  logic [31:0]      mem_q [FRAMES][16];

  state_t           state_q, state_d;
  logic             wp_q, wp_d;
  logic             rp_q, rp_d;
  logic [1:0]       occ_q, occ_d;
  logic [3:0]       rc_q, rc_d;
  logic             out_valid_q, out_valid_d;
  logic [15:0]      out_real_q, out_real_d;
  logic [15:0]      out_imag_q, out_imag_d;
  logic [3:0]       out_index_q, out_index_d;
  logic             out_last_q, out_last_d;
  logic [CNT_W-1:0] frame_cnt_q, frame_cnt_d;
  logic             overflow_q, overflow_d;
  logic             busy_q, busy_d;

  logic             hs, complete, slot_free, cap;
  logic [31:0]      rd_word;

  // NOTE: every signal driven here gets a default first, so no path through
  // the block can leave one unassigned and infer a latch.
  always_comb begin
    state_d     = state_q;
    wp_d        = wp_q;
    rp_d        = rp_q;
    rc_d        = rc_q;
    out_valid_d = out_valid_q;
    out_real_d  = out_real_q;
    out_imag_d  = out_imag_q;
    out_index_d = out_index_q;
    out_last_d  = out_last_q;
    frame_cnt_d = frame_cnt_q;
    overflow_d  = overflow_q;
    rd_word     = 32'd0;

    hs        = out_valid_q & out_ready;
    complete  = hs & (rc_q == 4'd15);
    // A frame finishing on this edge releases its slot before capture looks.
    slot_free = (occ_q < OCC_MAX) | complete;
    cap       = fft_valid & slot_free;

    occ_d = occ_q + {1'b0, cap} - {1'b0, complete};

    if (hs)       rc_d = rc_q + 4'd1;  // 15 wraps to 0 on completion
    if (complete) begin
      rp_d        = ptr_inc(rp_q);
      frame_cnt_d = frame_cnt_q + 1'b1;
    end
    if (cap)                     wp_d       = ptr_inc(wp_q);
    if (fft_valid && !slot_free) overflow_d = 1'b1;

    busy_d = (occ_d != 2'd0);

    case (state_q)
      IDLE:    if (occ_d != 2'd0) state_d = SEND;
      SEND:    if (occ_d == 2'd0) state_d = IDLE;
      default: state_d = IDLE;
    endcase

    out_valid_d = (state_d == SEND);

    // Preload the word that will be current after this edge. If that slot is
    // being written on this very edge, forward the incoming data instead.
    if (state_d == SEND) begin
      if (cap && (rp_d == wp_q)) rd_word = cap_word[rc_d];
      else                       rd_word = mem_q[rp_d][rc_d];
      out_real_d  = rd_word[31:16];
      out_imag_d  = rd_word[15:0];
      out_index_d = rc_d;
      out_last_d  = (rc_d == 4'd15);
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of every other flop.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      wp_q        <= 1'b0;
      rp_q        <= 1'b0;
      occ_q       <= 2'd0;
      rc_q        <= 4'd0;
      out_valid_q <= 1'b0;
      out_real_q  <= 16'd0;
      out_imag_q  <= 16'd0;
      out_index_q <= 4'd0;
      out_last_q  <= 1'b0;
      frame_cnt_q <= '0;
      overflow_q  <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      wp_q        <= wp_d;
      rp_q        <= rp_d;
      occ_q       <= occ_d;
      rc_q        <= rc_d;
      out_valid_q <= out_valid_d;
      out_real_q  <= out_real_d;
      out_imag_q  <= out_imag_d;
      out_index_q <= out_index_d;
      out_last_q  <= out_last_d;
      frame_cnt_q <= frame_cnt_d;
      overflow_q  <= overflow_d;
      busy_q      <= busy_d;
    end
  end

  // NOTE: the frame store has no reset; a slot is only read once occupancy
  // says it holds a captured frame, so its power-up contents never escape.
  always_ff @(posedge clk) begin
    if (cap) begin
      for (int i = 0; i < 16; i++) mem_q[wp_q][i] <= cap_word[i];
    end
  end

  assign out_valid = out_valid_q;
  assign out_real  = out_real_q;
  assign out_imag  = out_imag_q;
  assign out_index = out_index_q;
  assign out_last  = out_last_q;
  assign frame_cnt = frame_cnt_q;
  assign overflow  = overflow_q;
  assign busy      = busy_q;

endmodule
